// File: rtl/output_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : output_display
//  Purpose  : Memory-mapped output peripheral for the MIPS core. A CPU write
//             latches an unsigned value, a sequential shift-add-3 engine
//             converts it to BCD, and the result drives active-low
//             seven-segment digits with leading-zero blanking. The CPU is
//             stalled through halt_from_output while the conversion runs.
//  Option   : OUTPUT_DISPLAY_WAIT_ACK_EN - when defined, the stall is held
//             after each conversion until a fresh button press.
//  Ports    : clock            rising-edge system clock
//             reset            synchronous, active-low reset
//             write_enable     CPU output write strobe
//             value            unsigned value to display
//             button           acknowledge button (active-high, synchronized)
//             halt_from_output registered CPU stall request
//             segments         7*DIGITS active-low segments, gfedcba per digit,
//                              digit 0 least significant
//  Revision : 1.0 - initial release
// ============================================================================
module output_display #(
    parameter int DATA_WIDTH = 26,
    parameter int DIGITS     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH-1:0]   value,
    input  logic                    button,
    output logic                    halt_from_output,
    output logic [7*DIGITS-1:0]     segments
);

    localparam int c_count_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int c_bcd_w   = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONVERT  = 2'd1,
        WAIT_ACK = 2'd2,
        SHOW     = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_halt;
    logic [7*DIGITS-1:0]    r_segments;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [c_bcd_w-1:0]     r_bcd;
    logic [c_count_w-1:0]   r_count;
    // Set once all DATA_WIDTH shifts are done; the following cycle loads
    // the display from the finished BCD accumulator.
    logic                   r_last;

    logic [c_bcd_w-1:0]     w_bcd_adj;
    logic [7*DIGITS-1:0]    w_seg_next;
    logic                   w_blank;

`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
    // Previous button level; a press is button=1 while this is 0.
    logic                   r_is_pressed;
`else
    logic                   w_unused_button;
    assign w_unused_button = button;
`endif

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Walk from the top digit down; blanking stops at the first nonzero
    // digit, and digit 0 is always shown so zero displays as "0".
    always_comb begin
        w_seg_next = '1;
        w_blank    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((r_bcd[4*i +: 4] != 4'd0) || (i == 0)) begin
                w_blank = 1'b0;
            end
            if (!w_blank) begin
                w_seg_next[7*i +: 7] = seg_encode(r_bcd[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_halt       <= 1'b0;
            r_segments   <= '1;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_count      <= '0;
            r_last       <= 1'b0;
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
            r_is_pressed <= 1'b1;
`endif
        end else begin
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
            r_is_pressed <= button;
`endif
            case (r_state)
                IDLE, SHOW: begin
                    // Old digits stay on the display until the new result loads.
                    if (write_enable) begin
                        r_shift <= value;
                        r_bcd   <= '0;
                        r_count <= c_count_w'(DATA_WIDTH - 1);
                        r_last  <= 1'b0;
                        r_halt  <= 1'b1;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (!r_last) begin
                        r_bcd   <= {w_bcd_adj[c_bcd_w-2:0], r_shift[DATA_WIDTH-1]};
                        r_shift <= r_shift << 1;
                        if (r_count == '0) begin
                            r_last <= 1'b1;
                        end else begin
                            r_count <= r_count - c_count_w'(1);
                        end
                    end else begin
                        r_segments <= w_seg_next;
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
                        r_state    <= WAIT_ACK;
`else
                        r_halt     <= 1'b0;
                        r_state    <= SHOW;
`endif
                    end
                end
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
                WAIT_ACK: begin
                    if (button && !r_is_pressed) begin
                        r_halt  <= 1'b0;
                        r_state <= SHOW;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign halt_from_output = r_halt;
    assign segments         = r_segments;

endmodule
`default_nettype wire

// File: tb/tb_output_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_output_display
//  Purpose  : Self-checking bench for output_display. Expected digit patterns
//             are queued when a write is issued and compared when the
//             conversion finishes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_display;

    localparam int DW = 26;
    localparam int ND = 8;

    logic              clock        = 1'b0;
    logic              reset        = 1'b0;
    logic              write_enable = 1'b0;
    logic [DW-1:0]     value        = '0;
    logic              button       = 1'b0;
    logic              halt_from_output;
    logic [7*ND-1:0]   segments;

    int                tests = 0;
    int                fails = 0;
    logic [7*ND-1:0]   exp_q[$];
    logic [7*ND-1:0]   shown;

    always #5 clock = ~clock;

    output_display #(
        .DATA_WIDTH (DW),
        .DIGITS     (ND)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .write_enable     (write_enable),
        .value            (value),
        .button           (button),
        .halt_from_output (halt_from_output),
        .segments         (segments)
    );

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b1000000;
            1: enc = 7'b1111001;
            2: enc = 7'b0100100;
            3: enc = 7'b0110000;
            4: enc = 7'b0011001;
            5: enc = 7'b0010010;
            6: enc = 7'b0000010;
            7: enc = 7'b1111000;
            8: enc = 7'b0000000;
            9: enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] model(input longint unsigned v);
        int dg[ND];
        int top;
        logic [7*ND-1:0] r;
        top = 0;
        for (int i = 0; i < ND; i++) begin
            dg[i] = int'(v % 10);
            v     = v / 10;
            if (dg[i] != 0) top = i;
        end
        r = '1;
        for (int i = 0; i < ND; i++) begin
            if (i <= top) r[7*i +: 7] = enc(dg[i]);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [DW-1:0] v);
        write_enable = 1'b1;
        value        = v;
        tick();
        write_enable = 1'b0;
        exp_q.push_back(model(longint'(v)));
        tests++;
        if (halt_from_output !== 1'b1) begin
            fails++;
            $display("FAIL halt_rise: got %b want 1 (value %0d)", halt_from_output, v);
        end
    endtask

    // Runs one conversion from the cycle after the write was accepted. A
    // nonzero glitch_at pulses write_enable (value 1) before that shift edge.
    task automatic wait_done(input int glitch_at);
        logic [7*ND-1:0] e;
        for (int k = 1; k <= DW; k++) begin
            if (k == glitch_at) begin
                write_enable = 1'b1;
                value        = 1;
            end
            tick();
            write_enable = 1'b0;
            if (k == DW / 2) begin
                tests++;
                if (segments !== shown) begin
                    fails++;
                    $display("FAIL hold_old: got %h want %h", segments, shown);
                end
            end
        end
        tests++;
        if (halt_from_output !== 1'b1) begin
            fails++;
            $display("FAIL halt_conv: got %b want 1", halt_from_output);
        end
        tick();
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
        tests++;
        if (halt_from_output !== 1'b1) begin
            fails++;
            $display("FAIL halt_wait_ack: got %b want 1", halt_from_output);
        end
        button = 1'b1;
        tick();
        button = 1'b0;
`endif
        tests++;
        if (halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL halt_fall: got %b want 0", halt_from_output);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            if (segments !== e) begin
                fails++;
                $display("FAIL segments: got %h want %h", segments, e);
            end
            shown = e;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (segments !== {7*ND{1'b1}} || halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got seg %h halt %b want all ones / 0", segments, halt_from_output);
        end
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if (segments !== {7*ND{1'b1}} || halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got seg %h halt %b want all ones / 0", segments, halt_from_output);
        end
        shown = '1;
    endtask

    task automatic test_zero;
        do_write(0);
        wait_done(0);
        tests++;
        if (segments[6:0] !== 7'b1000000 || segments[7*ND-1:7] !== {7*(ND-1){1'b1}}) begin
            fails++;
            $display("FAIL zero_digits: got %h want only digit0=1000000", segments);
        end
    endtask

    task automatic test_digits;
        do_write(12345);
        wait_done(0);
        do_write(7);
        wait_done(0);
        tests++;
        if (segments[6:0] !== 7'b1111000) begin
            fails++;
            $display("FAIL seven_digit0: got %b want 1111000", segments[6:0]);
        end
    endtask

    task automatic test_max;
        do_write(DW'((1 << DW) - 1));
        wait_done(3);
        tests++;
        if (segments[7*ND-1 -: 7] !== 7'b0000010) begin
            fails++;
            $display("FAIL max_top_digit: got %b want 0000010", segments[7*ND-1 -: 7]);
        end
    endtask

`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
    task automatic test_ack;
        logic [7*ND-1:0] e;
        button = 1'b1;
        tick();
        do_write(305);
        repeat (DW + 1) tick();
        e = exp_q.pop_front();
        shown = e;
        tests++;
        if (segments !== e) begin
            fails++;
            $display("FAIL ack_segments: got %h want %h", segments, e);
        end
        repeat (3) tick();
        tests++;
        if (halt_from_output !== 1'b1) begin
            fails++;
            $display("FAIL ack_held: got %b want 1", halt_from_output);
        end
        button = 1'b0;
        tick();
        tests++;
        if (halt_from_output !== 1'b1) begin
            fails++;
            $display("FAIL ack_release: got %b want 1", halt_from_output);
        end
        button = 1'b1;
        tick();
        button = 1'b0;
        tests++;
        if (halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL ack_press: got %b want 0", halt_from_output);
        end
        do_write(88);
        wait_done(0);
    endtask
`endif

    task automatic test_reset_mid;
        do_write(999);
        repeat (10) tick();
        reset        = 1'b0;
        write_enable = 1'b1;
        value        = 5;
        button       = 1'b1;
        tick();
        tests++;
        if (segments !== {7*ND{1'b1}} || halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got seg %h halt %b want all ones / 0", segments, halt_from_output);
        end
        tick();
        reset        = 1'b1;
        write_enable = 1'b0;
        button       = 1'b0;
        tick();
        tests++;
        if (segments !== {7*ND{1'b1}} || halt_from_output !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after: got seg %h halt %b want all ones / 0", segments, halt_from_output);
        end
        exp_q.delete();
        shown = '1;
        do_write(42);
        wait_done(0);
    endtask

    task automatic test_back_to_back;
        do_write(100);
        wait_done(0);
        do_write(9876543);
        wait_done(0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_digits();
        test_max();
`ifdef OUTPUT_DISPLAY_WAIT_ACK_EN
        test_ack();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
